// File: rtl/mac_arb_pkg.sv
// Shared types and helpers for the complex-MAC arbiter and other round-robin
// shared-resource arbiters.
package mac_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for a requester vector; a single requester still needs one bit.
    function automatic int req_id_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    // LSB position of requester idx inside a packed per-requester bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/cmplx_mac_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning cyclically
// from last_id+1. Outputs one-hot, index and an any-request flag.
module rr_pick
    import mac_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = req_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [NUM_REQ-1:0] onehot,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [ID_W-1:0] cand;

    // Scan from farthest to nearest so the nearest set bit is the final winner.
    always_comb begin
        onehot = '0;
        idx    = '0;
        cand   = '0;
        any    = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last_id) + k) % NUM_REQ);
            if (req[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/cmplx_mac_arbiter.sv
// Burst-locking round-robin arbiter sharing one complex MAC among NUM_REQ FIR
// sequencers. Define MAC_ARB_WATCHDOG_EN to add the MAX_BURST grant watchdog.
module cmplx_mac_arbiter
    import mac_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 32,
    parameter  int DATA_SIZE = 16,
    localparam int ID_W      = req_id_w(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_xreal,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_ximag,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_creal,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_cimag,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [ID_W-1:0]               gnt_id,
    output logic                          busy,
    output logic                          mac_valid,
    output logic                          mac_last,
    output logic [DATA_SIZE-1:0]          mac_xreal,
    output logic [DATA_SIZE-1:0]          mac_ximag,
    output logic [DATA_SIZE-1:0]          mac_creal,
    output logic [DATA_SIZE-1:0]          mac_cimag,
    input  logic                          mac_ready,
    output logic                          wd_err
);

    arb_state_e           state_reg, state_next;
    logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
    logic [ID_W-1:0]      gnt_id_reg, gnt_id_next;
    logic [ID_W-1:0]      last_id_reg, last_id_next;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_any;

    logic [DATA_SIZE-1:0] xr_arr [NUM_REQ];
    logic [DATA_SIZE-1:0] xi_arr [NUM_REQ];
    logic [DATA_SIZE-1:0] cr_arr [NUM_REQ];
    logic [DATA_SIZE-1:0] ci_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign xr_arr[gi] = req_xreal[slice_lo(gi, DATA_SIZE) +: DATA_SIZE];
        assign xi_arr[gi] = req_ximag[slice_lo(gi, DATA_SIZE) +: DATA_SIZE];
        assign cr_arr[gi] = req_creal[slice_lo(gi, DATA_SIZE) +: DATA_SIZE];
        assign ci_arr[gi] = req_cimag[slice_lo(gi, DATA_SIZE) +: DATA_SIZE];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .last_id (last_id_reg),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .any     (pick_any)
    );

`ifdef MAC_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             wd_err_reg, wd_err_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            wd_err_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            wd_err_reg <= wd_err_next;
        end
    end

    assign wd_err = wd_err_reg;
`else
    logic [31:0] unused_max_burst;
    assign unused_max_burst = 32'(MAX_BURST);
    assign wd_err           = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= ARB;
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            last_id_reg <= ID_W'(NUM_REQ - 1);
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            gnt_id_reg  <= gnt_id_next;
            last_id_reg <= last_id_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        gnt_id_next  = gnt_id_reg;
        last_id_next = last_id_reg;
        busy         = 1'b0;
        mac_valid    = 1'b0;
        mac_last     = 1'b0;
        mac_xreal    = '0;
        mac_ximag    = '0;
        mac_creal    = '0;
        mac_cimag    = '0;
`ifdef MAC_ARB_WATCHDOG_EN
        cnt_next     = cnt_reg;
        wd_err_next  = wd_err_reg;
`endif
        case (state_reg)
            ARB: begin
                if (pick_any) begin
                    gnt_next    = pick_onehot;
                    gnt_id_next = pick_idx;
                    state_next  = GRANT;
`ifdef MAC_ARB_WATCHDOG_EN
                    cnt_next    = '0;
`endif
                end
            end
            GRANT: begin
                busy      = 1'b1;
                mac_xreal = xr_arr[gnt_id_reg];
                mac_ximag = xi_arr[gnt_id_reg];
                mac_creal = cr_arr[gnt_id_reg];
                mac_cimag = ci_arr[gnt_id_reg];
                // A dropped request must not leak a beat while it aborts.
                mac_valid = req_valid[gnt_id_reg] & req[gnt_id_reg];
                mac_last  = mac_valid & req_last[gnt_id_reg];
                if (!req[gnt_id_reg] || (mac_valid && mac_ready && mac_last)) begin
                    state_next   = ARB;
                    gnt_next     = '0;
                    last_id_next = gnt_id_reg;
                end
`ifdef MAC_ARB_WATCHDOG_EN
                else if (cnt_reg == CNT_W'(MAX_BURST - 1)) begin
                    // Bare last pulse tells the MAC to drop its partial sum.
                    mac_valid    = 1'b0;
                    mac_last     = 1'b1;
                    wd_err_next  = 1'b1;
                    state_next   = ARB;
                    gnt_next     = '0;
                    last_id_next = gnt_id_reg;
                end
                cnt_next = cnt_reg + 1'b1;
`endif
            end
            default: state_next = ARB;
        endcase
    end

    assign gnt    = gnt_reg;
    assign gnt_id = gnt_id_reg;

endmodule
